// File: rtl/axi_avst_gasket_pkg.sv
// Shared types and constants for the AXI4-Stream to Avalon-ST video gasket:
// framing state, pixel field positions and the buffered beat layout.
package axi_avst_gasket_pkg;

    localparam int AXI_DATA_W      = 64;
    localparam int AVST_DATA_W     = 96;
    localparam int COMP_W          = 10;
    localparam int AXI_PIX_STRIDE  = 32;
    localparam int AVST_LANE_W     = 16;
    localparam int PIXELS_PER_BEAT = 2;
    localparam int COMPS_PER_PIXEL = 3;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } gasket_state_e;

    typedef struct packed {
        logic [AVST_DATA_W-1:0] data;
        logic                   sop;
        logic                   eop;
    } avst_beat_t;

    // Each 10-bit colour component moves into the low bits of its own 16-bit lane.
    function automatic logic [AVST_DATA_W-1:0] map_pixels(input logic [AXI_DATA_W-1:0] tdata);
        logic [AVST_DATA_W-1:0] d;
        d = '0;
        for (int p = 0; p < PIXELS_PER_BEAT; p++) begin
            for (int c = 0; c < COMPS_PER_PIXEL; c++) begin
                d[(p*COMPS_PER_PIXEL + c)*AVST_LANE_W +: COMP_W] =
                    tdata[p*AXI_PIX_STRIDE + c*COMP_W +: COMP_W];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/avst_skid_buffer.sv
// Two-entry registered skid buffer; the head entry drives the output directly,
// so a beat written into an empty buffer is visible one cycle later.
module avst_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             ready_en;
    logic             push;
    logic             pop;

    // ready_en keeps in_ready low through reset and raises it on the first edge after.
    assign in_ready  = ready_en && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= 2'd0;
            head     <= '0;
            tail     <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_to_avalon_gasket.sv
// AXI4-Stream video to Avalon-ST gasket with SOF resynchronisation and line-length checking.
// Define AXI_TO_AVALON_STATS_EN to add the frame_count/err_count statistics outputs.
module axi_to_avalon_gasket
    import axi_avst_gasket_pkg::*;
#(
    parameter int LINE_BEATS = 960
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        axi_rx_tvalid,
    output logic        axi_rx_tready,
    input  logic [63:0] axi_rx_tdata,
    input  logic        axi_rx_tlast,
    input  logic [7:0]  axi_rx_tuser,
    input  logic        avst_source_ready,
    output logic        avst_source_valid,
    output logic [95:0] avst_source_data,
    output logic        avst_source_sop,
    output logic        avst_source_eop,
    output logic [3:0]  avst_source_empty,
    output logic        line_err
`ifdef AXI_TO_AVALON_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
`endif
);

    localparam int CNT_W = $clog2(LINE_BEATS + 1);
    localparam logic [CNT_W:0] ONE      = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] LEN_LAST = (CNT_W+1)'(LINE_BEATS);
    localparam logic [CNT_W:0] LEN_OVER = (CNT_W+1)'(LINE_BEATS + 1);
    localparam logic [CNT_W:0] CNT_SAT  = {1'b0, {CNT_W{1'b1}}};

    gasket_state_e    state, state_next;
    logic [CNT_W-1:0] beat_cnt, cnt_next;
    logic [CNT_W:0]   idx;
    logic             err_next;
    logic             sof;
    logic             fwd_beat;
    logic             accept;
    logic             tuser_unused;
    avst_beat_t       in_beat;
    avst_beat_t       out_beat;

    assign sof          = axi_rx_tuser[0];
    assign tuser_unused = ^axi_rx_tuser[7:1];
    assign fwd_beat     = (state == ACTIVE) || sof;
    assign accept       = axi_rx_tvalid && axi_rx_tready;

    assign in_beat.data = map_pixels(axi_rx_tdata);
    assign in_beat.sop  = sof;
    assign in_beat.eop  = axi_rx_tlast;

    avst_skid_buffer #(
        .WIDTH($bits(avst_beat_t))
    ) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (axi_rx_tvalid && fwd_beat),
        .in_ready (axi_rx_tready),
        .in_data  (in_beat),
        .out_valid(avst_source_valid),
        .out_ready(avst_source_ready),
        .out_data (out_beat)
    );

    assign avst_source_data  = out_beat.data;
    assign avst_source_sop   = out_beat.sop;
    assign avst_source_eop   = out_beat.eop;
    assign avst_source_empty = 4'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= WAIT_SOF;
            beat_cnt <= '0;
            line_err <= 1'b0;
        end else begin
            state    <= state_next;
            beat_cnt <= cnt_next;
            line_err <= err_next;
        end
    end

    // An SOF beat always counts as beat 1 of a fresh line, even when it interrupts one.
    assign idx = sof ? ONE : ({1'b0, beat_cnt} + ONE);

    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        err_next   = 1'b0;
        unique case (state)
            WAIT_SOF: if (accept && sof) state_next = ACTIVE;
            ACTIVE:   state_next = ACTIVE;
            default:  state_next = WAIT_SOF;
        endcase
        if (accept && fwd_beat) begin
            if (sof && (beat_cnt != '0)) err_next = 1'b1;
            if (axi_rx_tlast) begin
                if (idx != LEN_LAST) err_next = 1'b1;
                cnt_next = '0;
            end else begin
                if (idx == LEN_OVER) err_next = 1'b1;
                cnt_next = (idx > CNT_SAT) ? CNT_SAT[CNT_W-1:0] : idx[CNT_W-1:0];
            end
        end
    end

`ifdef AXI_TO_AVALON_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= 16'd0;
            err_count   <= 16'd0;
        end else begin
            if (accept && sof) frame_count <= frame_count + 16'd1;
            if (line_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_to_avalon_gasket.sv
// Scoreboard bench for axi_to_avalon_gasket (LINE_BEATS=4); stats checks need AXI_TO_AVALON_STATS_EN.
module tb_axi_to_avalon_gasket;
    import axi_avst_gasket_pkg::*;

    localparam int LB = 4;

    logic        clk;
    logic        resetn;
    logic        axi_rx_tvalid;
    logic        axi_rx_tready;
    logic [63:0] axi_rx_tdata;
    logic        axi_rx_tlast;
    logic [7:0]  axi_rx_tuser;
    logic        avst_source_ready;
    logic        avst_source_valid;
    logic [95:0] avst_source_data;
    logic        avst_source_sop;
    logic        avst_source_eop;
    logic [3:0]  avst_source_empty;
    logic        line_err;
`ifdef AXI_TO_AVALON_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] err_count;
`endif

    avst_beat_t exp_q[$];
    avst_beat_t last_beat;
    int         tests_run  = 0;
    int         failures   = 0;
    int         beats_seen = 0;
    int         err_pulses = 0;
    bit         tb_active  = 0;

    axi_to_avalon_gasket #(
        .LINE_BEATS(LB)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .axi_rx_tvalid    (axi_rx_tvalid),
        .axi_rx_tready    (axi_rx_tready),
        .axi_rx_tdata     (axi_rx_tdata),
        .axi_rx_tlast     (axi_rx_tlast),
        .axi_rx_tuser     (axi_rx_tuser),
        .avst_source_ready(avst_source_ready),
        .avst_source_valid(avst_source_valid),
        .avst_source_data (avst_source_data),
        .avst_source_sop  (avst_source_sop),
        .avst_source_eop  (avst_source_eop),
        .avst_source_empty(avst_source_empty),
        .line_err         (line_err)
`ifdef AXI_TO_AVALON_STATS_EN
        ,
        .frame_count      (frame_count),
        .err_count        (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected Avalon beat, written field by field from the pixel mapping table.
    function automatic avst_beat_t model_beat(input logic [63:0] td, input logic s, input logic l);
        avst_beat_t b;
        b = '0;
        b.data[9:0]   = td[9:0];
        b.data[25:16] = td[19:10];
        b.data[41:32] = td[29:20];
        b.data[57:48] = td[41:32];
        b.data[73:64] = td[51:42];
        b.data[89:80] = td[61:52];
        b.sop = s;
        b.eop = l;
        return b;
    endfunction

    // Output monitor: every consumed Avalon beat is checked against the scoreboard head.
    always @(negedge clk) begin
        avst_beat_t got;
        avst_beat_t exp;
        if (line_err) err_pulses++;
        if (resetn && avst_source_valid && avst_source_ready) begin
            got = '{data: avst_source_data, sop: avst_source_sop, eop: avst_source_eop};
            last_beat = got;
            beats_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_beat: got data=%h sop=%b eop=%b, required no beat",
                         got.data, got.sop, got.eop);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL beat_order: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                             got.data, got.sop, got.eop, exp.data, exp.sop, exp.eop);
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] td, input logic [7:0] tu, input logic tl, output int cycles);
        bit ok;
        ok = 0;
        cycles = 0;
        axi_rx_tdata  = td;
        axi_rx_tuser  = tu;
        axi_rx_tlast  = tl;
        axi_rx_tvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (axi_rx_tready) ok = 1;
            cycles++;
            @(posedge clk);
            #1;
        end
        axi_rx_tvalid = 1'b0;
        if (ok) begin
            if (tb_active || tu[0]) exp_q.push_back(model_beat(td, tu[0], tl));
            if (tu[0]) tb_active = 1;
        end else begin
            tests_run++;
            failures++;
            $display("[TB] FAIL accept_timeout: got tready=0 for 20 cycles, required acceptance");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        resetn        = 1'b0;
        axi_rx_tvalid = 1'b0;
        exp_q.delete();
        tb_active = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run += 6;
        if (axi_rx_tready !== 1'b0) begin failures++; $display("[TB] FAIL rst_tready: got %b, required 0", axi_rx_tready); end
        if (avst_source_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b, required 0", avst_source_valid); end
        if (avst_source_sop !== 1'b0) begin failures++; $display("[TB] FAIL rst_sop: got %b, required 0", avst_source_sop); end
        if (avst_source_eop !== 1'b0) begin failures++; $display("[TB] FAIL rst_eop: got %b, required 0", avst_source_eop); end
        if (avst_source_data !== 96'h0) begin failures++; $display("[TB] FAIL rst_data: got %h, required 0", avst_source_data); end
        if (line_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_line_err: got %b, required 0", line_err); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (axi_rx_tready !== 1'b0) begin failures++; $display("[TB] FAIL tready_before_edge: got %b, required 0", axi_rx_tready); end
        @(posedge clk);
        #1;
        tests_run++;
        if (axi_rx_tready !== 1'b1) begin failures++; $display("[TB] FAIL tready_first_edge: got %b, required 1", axi_rx_tready); end
    endtask

    task automatic test_pixel_map();
        int c;
        int b0;
        apply_reset();
        avst_source_ready = 1'b1;
        b0 = beats_seen;
        send_beat(64'h3FF00000_3FFFFC00, 8'h01, 1'b0, c);
        wait_drain();
        tests_run += 9;
        if (beats_seen - b0 != 1) begin failures++; $display("[TB] FAIL map_count: got %0d beats, required 1", beats_seen - b0); end
        if (last_beat.data[41:32] !== 10'h3FF) begin failures++; $display("[TB] FAIL map_41_32: got %h, required 3ff", last_beat.data[41:32]); end
        if (last_beat.data[25:16] !== 10'h3FF) begin failures++; $display("[TB] FAIL map_25_16: got %h, required 3ff", last_beat.data[25:16]); end
        if (last_beat.data[9:0] !== 10'h000) begin failures++; $display("[TB] FAIL map_9_0: got %h, required 000", last_beat.data[9:0]); end
        if (last_beat.data[89:80] !== 10'h3FF) begin failures++; $display("[TB] FAIL map_89_80: got %h, required 3ff", last_beat.data[89:80]); end
        if (last_beat.data[73:64] !== 10'h000) begin failures++; $display("[TB] FAIL map_73_64: got %h, required 000", last_beat.data[73:64]); end
        if (last_beat.data[57:48] !== 10'h000) begin failures++; $display("[TB] FAIL map_57_48: got %h, required 000", last_beat.data[57:48]); end
        if (last_beat.sop !== 1'b1) begin failures++; $display("[TB] FAIL map_sop: got %b, required 1", last_beat.sop); end
        if (avst_source_empty !== 4'd0) begin failures++; $display("[TB] FAIL empty: got %h, required 0", avst_source_empty); end
    endtask

    task automatic test_pre_sof();
        int c;
        int b0;
        apply_reset();
        avst_source_ready = 1'b1;
        b0 = beats_seen;
        for (int i = 0; i < 3; i++) begin
            send_beat({$urandom, $urandom}, 8'hFE, 1'b0, c);
            tests_run++;
            if (c != 1) begin failures++; $display("[TB] FAIL presof_tready: got %0d cycles to accept, required 1", c); end
        end
        send_beat(64'h0123_4567_89AB_CDEF, 8'h01, 1'b0, c);
        tests_run++;
        if (c != 1) begin failures++; $display("[TB] FAIL sof_tready: got %0d cycles to accept, required 1", c); end
        wait_drain();
        tests_run++;
        if (beats_seen - b0 != 1) begin failures++; $display("[TB] FAIL presof_count: got %0d beats, required 1", beats_seen - b0); end
    endtask

    task automatic test_backpressure();
        int c;
        int b0;
        bit held;
        apply_reset();
        avst_source_ready = 1'b0;
        b0 = beats_seen;
        send_beat(64'h1111_2222_3333_4444, 8'h01, 1'b0, c);
        send_beat(64'h5555_6666_7777_8888, 8'h00, 1'b0, c);
        axi_rx_tdata  = 64'h0FED_CBA9_8765_4321;
        axi_rx_tuser  = 8'h00;
        axi_rx_tlast  = 1'b0;
        axi_rx_tvalid = 1'b1;
        held = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (axi_rx_tready !== 1'b0) held = 0;
        end
        tests_run++;
        if (!held) begin failures++; $display("[TB] FAIL bp_tready: got tready=1 with 2 buffered, required 0"); end
        @(posedge clk);
        #1;
        avst_source_ready = 1'b1;
        send_beat(64'h0FED_CBA9_8765_4321, 8'h00, 1'b1, c);
        wait_drain();
        tests_run++;
        if (beats_seen - b0 != 3) begin failures++; $display("[TB] FAIL bp_count: got %0d beats, required 3", beats_seen - b0); end
    endtask

    task automatic test_line_length();
        int c;
        int e0;
        apply_reset();
        avst_source_ready = 1'b1;
        // short line: tlast on beat 3
        e0 = err_pulses;
        send_beat(64'h10, 8'h01, 1'b0, c);
        send_beat(64'h11, 8'h00, 1'b0, c);
        send_beat(64'h12, 8'h00, 1'b1, c);
        wait_drain();
        tests_run++;
        if (err_pulses - e0 != 1) begin failures++; $display("[TB] FAIL short_line: got %0d err cycles, required 1", err_pulses - e0); end
        // exact line
        e0 = err_pulses;
        for (int i = 1; i <= LB; i++) send_beat(64'(32'h20 + i), 8'h00, (i == LB), c);
        wait_drain();
        tests_run++;
        if (err_pulses - e0 != 0) begin failures++; $display("[TB] FAIL exact_line: got %0d err cycles, required 0", err_pulses - e0); end
        // long line: 5 beats without tlast
        e0 = err_pulses;
        for (int i = 1; i <= LB + 1; i++) send_beat(64'(32'h30 + i), 8'h00, 1'b0, c);
        wait_drain();
        tests_run++;
        if (err_pulses - e0 != 1) begin failures++; $display("[TB] FAIL long_line: got %0d err cycles, required 1", err_pulses - e0); end
        // SOF mid-line restarts the count at 1
        e0 = err_pulses;
        send_beat(64'h40, 8'h01, 1'b0, c);
        wait_drain();
        tests_run++;
        if (err_pulses - e0 != 1) begin failures++; $display("[TB] FAIL midline_sof: got %0d err cycles, required 1", err_pulses - e0); end
        e0 = err_pulses;
        for (int i = 2; i <= LB; i++) send_beat(64'(32'h40 + i), 8'h00, (i == LB), c);
        wait_drain();
        tests_run++;
        if (err_pulses - e0 != 0) begin failures++; $display("[TB] FAIL restart_count: got %0d err cycles, required 0", err_pulses - e0); end
    endtask

    task automatic test_reset_midline();
        int c;
        int b0;
        apply_reset();
        avst_source_ready = 1'b0;
        send_beat(64'hAAAA, 8'h01, 1'b0, c);
        send_beat(64'hBBBB, 8'h00, 1'b0, c);
        resetn = 1'b0;
        exp_q.delete();
        tb_active = 0;
        @(negedge clk);
        tests_run++;
        if (avst_source_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b, required 0", avst_source_valid); end
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        avst_source_ready = 1'b1;
        b0 = beats_seen;
        send_beat(64'hCCCC, 8'h00, 1'b0, c);
        send_beat(64'hDDDD, 8'h00, 1'b1, c);
        repeat (4) @(negedge clk);
        tests_run++;
        if (beats_seen != b0) begin failures++; $display("[TB] FAIL midrst_leak: got %0d beats, required 0", beats_seen - b0); end
        @(posedge clk);
        #1;
        send_beat(64'hEEEE, 8'h01, 1'b0, c);
        wait_drain();
        tests_run++;
        if (beats_seen - b0 != 1) begin failures++; $display("[TB] FAIL midrst_resync: got %0d beats, required 1", beats_seen - b0); end
    endtask

`ifdef AXI_TO_AVALON_STATS_EN
    task automatic test_stats();
        int c;
        apply_reset();
        avst_source_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 1; i <= LB; i++) send_beat(64'(f*16 + i), {7'd0, (i == 1)}, (i == LB), c);
        end
        send_beat(64'h99, 8'h00, 1'b0, c);
        send_beat(64'h9A, 8'h00, 1'b1, c);
        wait_drain();
        tests_run += 2;
        if (frame_count !== 16'd3) begin failures++; $display("[TB] FAIL frame_count: got %0d, required 3", frame_count); end
        if (err_count !== 16'd1) begin failures++; $display("[TB] FAIL err_count: got %0d, required 1", err_count); end
    endtask
`endif

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn            = 1'b0;
        axi_rx_tvalid     = 1'b0;
        axi_rx_tdata      = '0;
        axi_rx_tlast      = 1'b0;
        axi_rx_tuser      = '0;
        avst_source_ready = 1'b0;
        test_reset();
        test_pixel_map();
        test_pre_sof();
        test_backpressure();
        test_line_length();
        test_reset_midline();
`ifdef AXI_TO_AVALON_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/axi_to_avalon_gasket.md
AXI_TO_AVALON_GASKET -- requirements
Module: axi_to_avalon_gasket

Interface
REQ-001 SHALL have parameter: LINE_BEATS, 960, expected AXI beats (2 pixels each) per video line.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock for all logic.
- resetn  in  1  reset, asynchronous, active-low.
- axi_rx_tvalid  in  1  AXI4-S receiver valid.
- axi_rx_tready  out  1  AXI4-S receiver ready.
- axi_rx_tdata  in  64  two packed 30-bit RGB pixels.
- axi_rx_tlast  in  1  end of line.
- axi_rx_tuser  in  8  bit 0 = start of frame; other bits ignored.
- avst_source_ready  in  1  Avalon-ST ready from the oneAPI IP.
- avst_source_valid  out  1  Avalon-ST valid.
- avst_source_data  out  96  two pixels, 16-bit lanes.
- avst_source_sop  out  1  start of packet (frame).
- avst_source_eop  out  1  end of packet (line).
- avst_source_empty  out  4  always 0.
- line_err  out  1  one-cycle pulse on a line-length violation.

Function
REQ-003 SHALL implement a 2-entry skid buffer between AXI and Avalon sides.
- Data, sop and eop are registered; minimum latency is 1 cycle from the accepted AXI beat to avst_source_valid.
REQ-004 SHALL drive axi_rx_tready high whenever buffer occupancy is less than 2, and low at occupancy 2.
- A simultaneous push and pop leaves occupancy unchanged.
REQ-005 SHALL accept AXI beats only when tvalid and tready are both high.
REQ-006 SHALL present Avalon beats in order; a beat is consumed only when avst_source_valid and avst_source_ready are both high (ready latency 0).
REQ-007 SHALL map AXI tdata bits to avst_source_data as follows:
- tdata[9:0] to data[9:0]; tdata[19:10] to data[25:16]; tdata[29:20] to data[41:32].
- tdata[41:32] to data[57:48]; tdata[51:42] to data[73:64]; tdata[61:52] to data[89:80].
- All other data bits are 0.
REQ-008 SHALL set sop equal to tuser[0] and eop equal to tlast of the same beat.
REQ-009 SHALL implement states WAIT_SOF and ACTIVE:
- Reset enters WAIT_SOF.
- In WAIT_SOF, beats with tuser[0]=0 are accepted and discarded.
- A beat with tuser[0]=1 is forwarded and the state moves to ACTIVE.
- In ACTIVE, all beats are forwarded.
REQ-010 SHALL keep a beat counter, width clog2(LINE_BEATS+1):
- Cleared on reset and after each accepted tlast beat.
- Incremented on each accepted beat forwarded in ACTIVE (including the SOF beat).
- Saturates at its maximum.
REQ-011 SHALL pulse line_err for one cycle after any of these:
- an accepted tlast beat whose 1-based beat index is not LINE_BEATS;
- an accepted non-tlast beat that would be beat LINE_BEATS+1;
- a tuser[0]=1 beat arriving mid-line (counter nonzero).
REQ-012 On a mid-line tuser[0]=1 beat, SHALL forward it with sop=1 and restart the counter at 1.
REQ-013 SHALL hold avst_source_empty at 0.

Reset
REQ-014 During reset, outputs SHALL be: axi_rx_tready=0, avst_source_valid=0, sop=0, eop=0, data=0, line_err=0; buffer empty, state WAIT_SOF, counter 0.
REQ-015 SHALL assert axi_rx_tready on the first clk edge after resetn deasserts.
REQ-016 Reset mid-frame SHALL flush the buffer with no partial beats emitted afterwards; resynchronisation is to the next SOF.

Configuration
REQ-017 With AXI_TO_AVALON_STATS_EN defined, SHALL add two outputs:
- frame_count  out  16  accepted SOF beats, wrapping at 2^16.
- err_count  out  16  line_err pulses, saturating at 0xFFFF.
- Both reset to 0.
REQ-018 Without AXI_TO_AVALON_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-019 A shared package axi_avst_gasket_pkg SHALL hold:
- the state enum typedef;
- pixel field bit-position constants;
- a typedef for the packed beat struct {data[95:0], sop, eop}.
REQ-020 The skid buffer SHALL be a sub-module, avst_skid_buffer, parameterised by payload width.

Verification
REQ-021 Bench SHALL cover:
- Pixel mapping: tdata=0x3FF00000_3FFFFC00 with tuser=1, tlast=0 -> one beat; data[41:32]=0x3FF, data[25:16]=0x3FF, data[9:0]=0, data[89:80]=0x3FF, data[73:64]=0, data[57:48]=0; sop=1.
- Pre-SOF discard: 3 beats with tuser=0, then an SOF beat -> only the SOF beat appears on Avalon; tready stays 1 throughout.
- Backpressure: avst_source_ready=0 with continuous input -> tready drops after 2 accepted beats; when ready returns, 2 beats drain in order with no loss or duplication.
- Line length, LINE_BEATS=4: tlast on beat 3 -> line_err pulses once; tlast on beat 4 -> no pulse; 5 beats without tlast -> pulse.
- Reset mid-line: resetn low for 2 cycles with 2 beats buffered -> avst_source_valid=0 from reset; nothing is emitted until the next tuser=1 beat.
- Stats build: 3 frames plus 1 bad line -> frame_count=3, err_count=1.
